// File: rtl/indec_pkg.sv
// Shared definitions for the sequencing instruction decoder.
//   - opcode/op field constants
//   - one-hot nsel encodings for the register-file port
//   - FSM state enum
//   - sext_bit: one bit of a sign-extended immediate
package indec_pkg;

    localparam logic [2:0] OPC_ALU = 3'b101;
    localparam logic [2:0] OPC_MOV = 3'b110;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_CMP  = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_MVN  = 2'b11;
    localparam logic [1:0] OP_MOVR = 2'b00;
    localparam logic [1:0] OP_MOVI = 2'b10;

    localparam logic [2:0] NSEL_NONE = 3'b000;
    localparam logic [2:0] NSEL_RN   = 3'b001;
    localparam logic [2:0] NSEL_RD   = 3'b010;
    localparam logic [2:0] NSEL_RM   = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_RN,
        ST_RD_RM,
        ST_WR_RD,
        ST_WR_RN,
        ST_FIN
    } state_t;

    // Bit idx of v sign-extended from bit msb. Any idx above msb (including
    // idx >= 8) takes the sign bit, so the index into v is always in range.
    function automatic logic sext_bit(input logic [7:0] v, input logic [2:0] msb, input int idx);
        if (idx > int'(msb))
            return v[msb];
        else
            return v[idx[2:0]];
    endfunction

endpackage

// File: rtl/indec_sched.sv
// Combinational schedule lookup for the sequencing decoder.
//   new_opcode/new_op : fields of the instruction being offered (first step)
//   cur_opcode/cur_op : fields of the latched instruction (step walk)
//   state             : current FSM state
//   first_state       : first state of the offered instruction's schedule
//   step_next         : state following the current step
//   step_last         : current step is the final one of the schedule
module indec_sched
    import indec_pkg::*;
(
    input  logic [2:0] new_opcode,
    input  logic [1:0] new_op,
    input  logic [2:0] cur_opcode,
    input  logic [1:0] cur_op,
    input  state_t     state,
    output state_t     first_state,
    output state_t     step_next,
    output logic       step_last
);

    always_comb begin
        first_state = ST_FIN;
        if (new_opcode == OPC_ALU) begin
            if (new_op == OP_MVN)
                first_state = ST_RD_RM;
            else
                first_state = ST_RD_RN;
        end else if (new_opcode == OPC_MOV) begin
            if (new_op == OP_MOVR)
                first_state = ST_RD_RM;
            else if (new_op == OP_MOVI)
                first_state = ST_WR_RN;
        end
    end

    // Only CMP stops after the Rm read; every other schedule that reads Rm
    // goes on to write Rd.
    always_comb begin
        step_next = ST_IDLE;
        step_last = 1'b0;
        case (state)
            ST_RD_RN: step_next = ST_RD_RM;
            ST_RD_RM: begin
                if (cur_opcode == OPC_ALU && cur_op == OP_CMP)
                    step_last = 1'b1;
                else
                    step_next = ST_WR_RD;
            end
            ST_WR_RD: step_last = 1'b1;
            ST_WR_RN: step_last = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/indec_seq.sv
// Registered, sequencing instruction decoder. Latches one instruction per
// valid/ready transfer, holds its decoded fields, and walks the register-file
// port through the instruction's read/write schedule one step per cycle.
//
// State table:
//   IDLE  | waiting for an instruction, in_ready=1
//   RD_RN | read step, nsel=Rn
//   RD_RM | read step, nsel=Rm
//   WR_RD | write step, nsel=Rd
//   WR_RN | write step, nsel=Rn (MOV immediate)
//   FIN   | zero-step instruction, one cycle
//
// Ports:
//   clk, reset (sync, active-high)
//   in[15:0], in_valid, in_ready       instruction handshake
//   stall                              hold current step
//   opcode, op, ALUop, shift, sximm5, sximm8   decoded fields of latched instr
//   nsel, readnum, writenum, step_rd, step_wr  register-port schedule
//   done, illegal                      completion / trap pulses
//
// Build option: INDEC_ILLEGAL_TRAP_EN defined makes unsupported opcodes pulse
// illegal instead of done.
module indec_seq
    import indec_pkg::*;
#(
    parameter int DW        = 16,
    parameter bit BACK2BACK = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [15:0]   in,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          stall,
    output logic [2:0]    opcode,
    output logic [1:0]    op,
    output logic [1:0]    ALUop,
    output logic [1:0]    shift,
    output logic [DW-1:0] sximm5,
    output logic [DW-1:0] sximm8,
    output logic [2:0]    nsel,
    output logic [2:0]    readnum,
    output logic [2:0]    writenum,
    output logic          step_rd,
    output logic          step_wr,
    output logic          done,
    output logic          illegal
);

    state_t      state_q, state_d;
    state_t      first_state, step_next;
    logic        step_last;
    logic [15:0] instr_q;
    logic        in_step, step_end, fin, wrap, accept;
    logic [2:0]  regsel;

    indec_sched u_sched (
        .new_opcode  (in[15:13]),
        .new_op      (in[12:11]),
        .cur_opcode  (instr_q[15:13]),
        .cur_op      (instr_q[12:11]),
        .state       (state_q),
        .first_state (first_state),
        .step_next   (step_next),
        .step_last   (step_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept)
                instr_q <= in;
        end
    end

    assign opcode = instr_q[15:13];
    assign op     = instr_q[12:11];
    assign ALUop  = instr_q[12:11];
    assign shift  = instr_q[4:3];

    for (genvar i = 0; i < DW; i++) begin : g_sext
        assign sximm5[i] = sext_bit(instr_q[7:0], 3'd4, i);
        assign sximm8[i] = sext_bit(instr_q[7:0], 3'd7, i);
    end

    always_comb begin
        nsel    = NSEL_NONE;
        step_rd = 1'b0;
        step_wr = 1'b0;
        case (state_q)
            ST_RD_RN: begin nsel = NSEL_RN; step_rd = 1'b1; end
            ST_RD_RM: begin nsel = NSEL_RM; step_rd = 1'b1; end
            ST_WR_RD: begin nsel = NSEL_RD; step_wr = 1'b1; end
            ST_WR_RN: begin nsel = NSEL_RN; step_wr = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        regsel = 3'd0;
        case (nsel)
            NSEL_RN: regsel = instr_q[10:8];
            NSEL_RD: regsel = instr_q[7:5];
            NSEL_RM: regsel = instr_q[2:0];
            default: ;
        endcase
    end

    assign readnum  = regsel;
    assign writenum = regsel;

    assign in_step  = step_rd | step_wr;
    assign step_end = in_step & step_last & ~stall;
    assign fin      = (state_q == ST_FIN);
    // Cycle in which the current instruction finishes (normally or via FIN);
    // with BACK2BACK the next instruction may be taken in the same cycle.
    assign wrap     = step_end | fin;
    assign in_ready = (state_q == ST_IDLE) | (BACK2BACK & wrap);
    assign accept   = in_valid & in_ready;

`ifdef INDEC_ILLEGAL_TRAP_EN
    // With the trap enabled FIN is reached only by unsupported instructions.
    assign done    = step_end;
    assign illegal = fin;
`else
    assign done    = step_end | fin;
    assign illegal = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        if (state_q == ST_IDLE) begin
            if (accept)
                state_d = first_state;
        end else if (wrap) begin
            state_d = accept ? first_state : ST_IDLE;
        end else if (in_step && !stall) begin
            state_d = step_next;
        end
    end

endmodule

// File: tb/tb_indec_seq.sv
module tb_indec_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in;
    logic        in_valid;
    logic        in_ready;
    logic        stall;
    logic [2:0]  opcode;
    logic [1:0]  op;
    logic [1:0]  ALUop;
    logic [1:0]  shift;
    logic [15:0] sximm5;
    logic [15:0] sximm8;
    logic [2:0]  nsel;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        step_rd;
    logic        step_wr;
    logic        done;
    logic        illegal;

    int n_checks = 0;
    int n_fail   = 0;

    indec_seq #(.DW(16), .BACK2BACK(1'b1)) dut (
        .clk      (clk),
        .reset    (reset),
        .in       (in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .stall    (stall),
        .opcode   (opcode),
        .op       (op),
        .ALUop    (ALUop),
        .shift    (shift),
        .sximm5   (sximm5),
        .sximm8   (sximm8),
        .nsel     (nsel),
        .readnum  (readnum),
        .writenum (writenum),
        .step_rd  (step_rd),
        .step_wr  (step_wr),
        .done     (done),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check a step cycle: nsel, rd/wr flags, register number, done.
    task automatic chk_step(input string tag, input logic [2:0] e_nsel, input logic e_rd,
                            input logic e_wr, input logic [2:0] e_reg, input logic e_done);
        chk({tag, ".nsel"},    32'(nsel),    32'(e_nsel));
        chk({tag, ".step_rd"}, 32'(step_rd), 32'(e_rd));
        chk({tag, ".step_wr"}, 32'(step_wr), 32'(e_wr));
        if (e_rd) chk({tag, ".readnum"},  32'(readnum),  32'(e_reg));
        if (e_wr) chk({tag, ".writenum"}, 32'(writenum), 32'(e_reg));
        chk({tag, ".done"},    32'(done),    32'(e_done));
        chk({tag, ".illegal"}, 32'(illegal), 32'd0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".nsel"},     32'(nsel),     32'd0);
        chk({tag, ".step_rd"},  32'(step_rd),  32'd0);
        chk({tag, ".step_wr"},  32'(step_wr),  32'd0);
        chk({tag, ".done"},     32'(done),     32'd0);
        chk({tag, ".illegal"},  32'(illegal),  32'd0);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        reset    = 1'b1;
        in       = 16'h0000;
        in_valid = 1'b0;
        stall    = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk_idle("rst");
        chk("rst.opcode", 32'(opcode), 32'd0);
        chk("rst.sximm8", 32'(sximm8), 32'd0);
        chk("rst.readnum", 32'(readnum), 32'd0);

        // ADD R2,R1,R0
        in = 16'hA140; in_valid = 1'b1;
        #1 chk("add.ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0; in = 16'h0000;
        #1;
        chk("add.opcode", 32'(opcode), 32'h5);
        chk("add.aluop", 32'(ALUop), 32'h0);
        chk("add.s1.ready", 32'(in_ready), 32'd0);
        chk_step("add.s1", 3'b001, 1'b1, 1'b0, 3'd1, 1'b0);
        tick(); #1;
        chk_step("add.s2", 3'b100, 1'b1, 1'b0, 3'd0, 1'b0);
        tick(); #1;
        chk_step("add.s3", 3'b010, 1'b0, 1'b1, 3'd2, 1'b1);
        chk("add.s3.ready", 32'(in_ready), 32'd1);
        tick(); #1;
        chk_idle("add.end");

        // MOV R3,#-5
        in = 16'hD3FB; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; in = 16'h0000;
        #1;
        chk_step("movi.s1", 3'b001, 1'b0, 1'b1, 3'd3, 1'b1);
        chk("movi.sximm8", 32'(sximm8), 32'h0000FFFB);
        chk("movi.sximm5", 32'(sximm5), 32'h0000FFFB);
        chk("movi.op", 32'(op), 32'h2);
        tick(); #1;
        chk_idle("movi.end");

        // CMP R1,R2 with MVN R4,R5,LSL#1 held on the input while busy
        in = 16'hA902; in_valid = 1'b1;
        tick();
        in = 16'hB88D; in_valid = 1'b1;
        #1;
        chk("cmp.s1.ready", 32'(in_ready), 32'd0);
        chk("cmp.op", 32'(op), 32'h1);
        chk_step("cmp.s1", 3'b001, 1'b1, 1'b0, 3'd1, 1'b0);
        tick(); #1;
        chk_step("cmp.s2", 3'b100, 1'b1, 1'b0, 3'd2, 1'b1);
        chk("cmp.s2.ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0; in = 16'h0000;
        #1;
        chk_step("mvn.s1", 3'b100, 1'b1, 1'b0, 3'd5, 1'b0);
        chk("mvn.shift", 32'(shift), 32'h1);
        chk("mvn.aluop", 32'(ALUop), 32'h3);
        tick(); #1;
        chk_step("mvn.s2", 3'b010, 1'b0, 1'b1, 3'd4, 1'b1);
        tick(); #1;
        chk_idle("mvn.end");

        // MOV R6,R7 with stall on the first step, then ADD queued back-to-back
        in = 16'hC0C7; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; in = 16'h0000; stall = 1'b1;
        #1;
        chk_step("movr.c1", 3'b100, 1'b1, 1'b0, 3'd7, 1'b0);
        tick(); #1;
        chk_step("movr.c2", 3'b100, 1'b1, 1'b0, 3'd7, 1'b0);
        tick(); #1;
        chk_step("movr.c3", 3'b100, 1'b1, 1'b0, 3'd7, 1'b0);
        tick();
        stall = 1'b0;
        #1;
        chk_step("movr.c4", 3'b100, 1'b1, 1'b0, 3'd7, 1'b0);
        tick();
        in = 16'hA140; in_valid = 1'b1;
        #1;
        chk_step("movr.wr", 3'b010, 1'b0, 1'b1, 3'd6, 1'b1);
        chk("movr.wr.ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0; in = 16'h0000;
        #1;
        chk_step("b2b.s1", 3'b001, 1'b1, 1'b0, 3'd1, 1'b0);
        tick(); #1;
        chk_step("b2b.s2", 3'b100, 1'b1, 1'b0, 3'd0, 1'b0);

        // Reset in RD_RM of ADD
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk_idle("rst2");
        chk("rst2.opcode", 32'(opcode), 32'd0);
        in = 16'hD3FB; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; in = 16'h0000;
        #1;
        chk_step("rst2.movi", 3'b001, 1'b0, 1'b1, 3'd3, 1'b1);
        tick(); #1;
        chk_idle("rst2.end");

        // Unsupported opcode; stall must be ignored in FIN
        in = 16'h0000; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; stall = 1'b1;
        #1;
        chk("ill.step_rd", 32'(step_rd), 32'd0);
        chk("ill.step_wr", 32'(step_wr), 32'd0);
        chk("ill.nsel", 32'(nsel), 32'd0);
`ifdef INDEC_ILLEGAL_TRAP_EN
        chk("ill.illegal", 32'(illegal), 32'd1);
        chk("ill.done", 32'(done), 32'd0);
`else
        chk("ill.illegal", 32'(illegal), 32'd0);
        chk("ill.done", 32'(done), 32'd1);
`endif
        tick();
        stall = 1'b0;
        #1;
        chk_idle("ill.end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
